// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback, owns the memory handshake, timeout and halt flags.
module rv32i_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state
);

  // Memory handshake: a transfer completes in any cycle where mem_req and mem_ready are
  // both 1; mem_ready is ignored whenever mem_req is 0, and mem_req is never withdrawn early.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic                   halted_q, halted_d;
  logic                   illegal_q, illegal_d;
  logic                   bus_err_q, bus_err_d;
  logic [7:0]             tmo_q, tmo_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   waiting;
  logic                   timeout;
  logic                   known_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    known_op  = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                               OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE};
    waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
    // Reaching the limit only errors if ready is still absent in that same cycle.
    timeout   = waiting && !mem_ready && (tmo_q == TMO_LAST);
    tmo_d     = (waiting && !mem_ready) ? tmo_q + 8'd1 : 8'd0;
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    instret_d = instret_q + INSTRET_W'(pc_we);
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (known_op) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = (opcode != OP_SYSTEM);
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LUI, OP_AUIPC, OP_OP, OP_IMM, OP_JAL, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:                                state_d = S_MEM;
          OP_BRANCH, OP_FENCE:                              state_d = S_FETCH;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (state_d == S_HALT) halted_d = 1'b1;
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 2'b00;
    rf_we   = 1'b0;
    wb_sel  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        if (opcode == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end else if (opcode == OP_FENCE) begin
          pc_we = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        pc_we   = mem_ready && (opcode == OP_STORE);
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (opcode == OP_JAL || opcode == OP_JALR) begin
          wb_sel = 2'b10;
          pc_sel = 2'b01;
        end else if (opcode == OP_LOAD) begin
          wb_sel = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: doc/rv32i_ctrl_fsm.md
Name: rv32i_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the PC, IR, register-file and memory enables around the combinational instruction decoder and ALU. It owns the instruction/data memory request handshake, memory timeout detection, halt/illegal detection and a retired-instruction counter. It sits between the decoder, the datapath register enables and the shared memory port.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ready before bus error (1..255)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous active-high reset
opcode  in  7  instruction[6:0] from IR (valid from DECODE onward)
branch_taken  in  1  datapath branch comparison result, valid in EXEC
mem_ready  in  1  memory acknowledge for current request
mem_req  out  1  memory request (FETCH, MEM)
mem_we  out  1  1 = store, 0 = read; meaningful only with mem_req
ir_we  out  1  load IR with memory read data
pc_we  out  1  update PC
pc_sel  out  2  00 PC+4, 01 ALU target, others reserved (never driven)
rf_we  out  1  register file write
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
halted  out  1  sticky halt indication
illegal  out  1  sticky: halt caused by unknown opcode
bus_err  out  1  sticky: halt caused by memory timeout
instret  out  INSTRET_W  retired-instruction count
state  out  3  current state (debug)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 unreachable, recovers to IDLE.
- Reset (async): state=IDLE; instret=0; halted/illegal/bus_err=0; timeout counter=0. All Moore outputs 0 while in reset and in IDLE.
- IDLE -> FETCH unconditionally (one cycle after reset release).
- FETCH: mem_req=1, mem_we=0. On mem_ready: ir_we=1 in the same cycle, go to DECODE.
- DECODE -> HALT if opcode is 1110011 (ECALL/EBREAK) or not one of {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111}. For an unknown opcode, set illegal=1. Otherwise go to EXEC.
- EXEC by opcode:
  - LUI, AUIPC, OP, OP-IMM, JAL, JALR -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: pc_we=1, pc_sel=01 if branch_taken else 00; retire; go to FETCH.
  - FENCE: pc_we=1, pc_sel=00; retire; go to FETCH.
- MEM: mem_req=1, mem_we=1 for STORE, else 0. On mem_ready:
  - LOAD -> WB.
  - STORE: pc_we=1, pc_sel=00, retire, go to FETCH.
- WB: rf_we=1, pc_we=1; retire; go to FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_sel: 01 for JAL/JALR, 00 otherwise.
- Retire: instret increments by 1, wrapping modulo 2^INSTRET_W, in exactly the cycle pc_we=1. pc_we and rf_we are never asserted outside EXEC/MEM/WB.
- Outputs are Moore/Mealy combinational from the state register plus opcode, branch_taken and mem_ready. No output depends on mem_ready outside FETCH/MEM.
- Timeout: counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0. If it reaches MEM_TIMEOUT with mem_ready still 0, go to HALT and set bus_err=1. mem_ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal progress, no error.
- mem_ready while mem_req=0 is ignored.
- HALT: all enables 0, halted=1. Stays in HALT until rst; flags are sticky.
- Async reset mid-transaction drops mem_req immediately; no partial PC/RF write occurs.

Test Plan:
- ALU op: reset, memory returns opcode 0110011 with 1-cycle ready -> states 0,1,2,3,5,1; rf_we=1, wb_sel=00, pc_we=1, pc_sel=00 in WB; instret=1.
- Load with wait: opcode 0000011, mem_ready delayed 3 cycles in MEM -> mem_req=1, mem_we=0 held 4 cycles; then WB with wb_sel=01; instret increments once.
- Branch both ways: opcode 1100011 with branch_taken=1 -> pc_sel=01 in EXEC; repeat with 0 -> pc_sel=00; no rf_we in either case; instret +2 total.
- JAL then STORE: opcode 1101111 -> WB wb_sel=10, pc_sel=01. Opcode 0100011 -> MEM mem_we=1, pc_we in MEM, rf_we never 1.
- Halt cases: opcode 1110011 -> HALT, halted=1, illegal=0. After a fresh reset, opcode 1111111 -> halted=1, illegal=1. Further mem_ready pulses change nothing; instret frozen.
- Timeout/reset: mem_ready held 0 in FETCH -> bus_err=1 after 15 cycles; ready at exactly cycle 15 -> no error. Assert rst during MEM -> state=0, mem_req=0 immediately, instret=0.
